enc16x4_seq: RTL and testbench
==============================

# enc16x4_seq

Sequential 16-to-4 encoder: the reverse path of the team's 4x16 one-hot decoder. Captures a 16-bit request word on a load strobe and emits the 4-bit index `{w,x,y,z}` of every set bit, one per accepted beat, in priority order, over a valid/ready handshake. Sits between request-line sources and logic that consumes binary codes. It also flags non-one-hot inputs so the decoder path can be cross-checked.

## Interface
- `PRIORITY_LOW`, default 1: 1 = lowest set index emitted first; 0 = highest first.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `d_in`  input  16  request word; bit i corresponds to decoder output d_i.
- `load`  input  1  capture strobe; sampled only when `busy`=0.
- `code`  output  4  index of current bit, `code[3:0]` = `{w,x,y,z}`.
- `valid`  output  1  `code` is presentable.
- `ready`  input  1  consumer accepts `code` when `valid`&`ready` at a rising edge.
- `busy`  output  1  pending bits remain; loads ignored.
- `multi`  output  1  captured word had ≥2 bits set (not one-hot).
- `none`  output  1  one-cycle pulse: load captured all-zero word.
- `done`  output  1  one-cycle pulse: last pending code accepted.

## Operation
- All outputs registered. Reset values: `code`=0, `valid`=0, `busy`=0, `multi`=0, `none`=0, `done`=0, pending register=0. State=IDLE.
- States: IDLE, EMIT.
- IDLE, `load`=1, `d_in`≠0: pending←`d_in`; `multi`←(popcount>1); `code`←selected index; `valid`←1; `busy`←1; go EMIT.
- IDLE, `load`=1, `d_in`=0: `none`=1 next cycle; `multi`←0; stay IDLE; `valid` stays 0.
- IDLE, `load`=0: hold; `multi` retains last value.
- Selected index: lowest set pending bit if `PRIORITY_LOW`=1, else highest.
- EMIT, `valid`&`ready`: clear the selected bit in pending.
  - Bits remain: `code`←next selected index; `valid` stays 1.
  - No bits remain: `valid`←0, `busy`←0, `done`=1 for one cycle, `code` holds last value, go IDLE.
- EMIT, `ready`=0: `code`, `valid`, and pending are held unchanged. `code` never changes while `valid`=1 and not accepted.
- `load` during EMIT is ignored. `d_in` is not re-sampled and `multi` is unchanged.
- `load` in the same cycle that `done` is asserted is accepted, because state is already IDLE.
- `done` and `none` are never asserted together.
- `rst` asserted at any time forces the reset values immediately. Pending bits are discarded and no `done` is issued.

## Timing
- Load latency: `load` sampled at edge k → `valid`=1 with first `code` after edge k.
- Throughput: one code per cycle while `ready`=1. Accept at edge m → next `code` after edge m.
- N set bits with `ready` held 1: `valid` high exactly N cycles; `done` high in cycle N+1 after load.
- `busy` high from edge after load to edge after final accept, coincident with `valid` when `ready`=1.
- Minimum load-to-load spacing: N+1 cycles; back-to-back single-bit words every 2 cycles.
- `ready` may toggle freely, with no combinational path from `ready` to any output.

## Test plan
- Single bit: load `d_in`=0x0100, `ready`=1 → `code`=8 for one cycle, `multi`=0, then `done` pulse; `busy` falls with `valid`.
- Multi-bit, `PRIORITY_LOW`=1: load 0x8005, `ready`=1 → `code` 0, 2, 15 on consecutive cycles, `multi`=1, `done` in 4th cycle. With `PRIORITY_LOW`=0 → 15, 2, 0.
- Backpressure: load 0x0003, `ready`=0 for 5 cycles → `code`=0, `valid`=1 stable. Then `ready`=1 → `code`=1, then `done`.
- Zero word: load 0x0000 → `none`=1 for one cycle, `valid`/`busy`/`done` stay 0, `multi`=0.
- Load while busy: load 0x0030, pulse `load` with `d_in`=0xFFFF during EMIT → only codes 4, 5 emitted, `multi`=1. Also confirm a `load` in the `done` cycle is captured.
- Exhaustive one-hot sweep: each `d_in`=1<<i for i=0..15 → `code`=i, `multi`=0, matching the 4x16 decoder inverse. Additionally, assert `rst` mid-EMIT of 0xFFFF → all outputs 0 immediately, no `done`.

Source files
------------

// File: rtl/enc16x4_seq_if.sv
// Request/code handshake bundle for the sequential 16-to-4 encoder.
// The master drives request words and ready; the slave returns codes and status.
interface enc16x4_seq_if;
    logic [15:0] d_in;
    logic        load;
    logic        ready;
    logic [3:0]  code;
    logic        valid;
    logic        busy;
    logic        multi;
    logic        none;
    logic        done;

    modport master (
        output d_in, load, ready,
        input  code, valid, busy, multi, none, done
    );

    modport slave (
        input  d_in, load, ready,
        output code, valid, busy, multi, none, done
    );
endinterface

// File: rtl/enc16x4_seq.sv
// Sequential 16-to-4 encoder: captures a request word and emits the index of
// every set bit in priority order over a valid/ready handshake.
module enc16x4_seq #(
    parameter bit PRIORITY_LOW = 1'b1
) (
    input logic          clk,
    input logic          rst,
    enc16x4_seq_if.slave bus
);
    localparam int unsigned W_D = 16;
    localparam int unsigned W_C = 4;

    typedef enum logic {IDLE, EMIT} state_e;

    state_e         state_q;
    logic [W_D-1:0] pend_q;
    logic [W_C-1:0] code_q;
    logic           valid_q;
    logic           busy_q;
    logic           multi_q;
    logic           none_q;
    logic           done_q;

    logic [W_D-1:0] pend_d;
    logic [W_C-1:0] next_code_d;
    logic [W_C-1:0] load_code_d;
    logic           load_multi_d;

    // Priority pick: the last match in the scan direction wins.
    function automatic logic [W_C-1:0] sel_idx(input logic [W_D-1:0] v);
        logic [W_C-1:0] idx;
        idx = '0;
        if (PRIORITY_LOW) begin
            for (int i = int'(W_D) - 1; i >= 0; i--)
                if (v[i]) idx = W_C'(i);
        end else begin
            for (int i = 0; i < int'(W_D); i++)
                if (v[i]) idx = W_C'(i);
        end
        return idx;
    endfunction

    always_comb begin
        pend_d       = pend_q & ~(W_D'(1) << code_q);
        next_code_d  = sel_idx(pend_d);
        load_code_d  = sel_idx(bus.d_in);
        load_multi_d = |(bus.d_in & (bus.d_in - W_D'(1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            multi_q <= 1'b0;
            none_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            none_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        if (bus.d_in != '0) begin
                            pend_q  <= bus.d_in;
                            multi_q <= load_multi_d;
                            code_q  <= load_code_d;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= EMIT;
                        end else begin
                            none_q  <= 1'b1;
                            multi_q <= 1'b0;
                        end
                    end
                end
                EMIT: begin
                    // Loads are ignored here; code holds until accepted.
                    if (valid_q && bus.ready) begin
                        if (pend_d != '0) begin
                            pend_q <= pend_d;
                            code_q <= next_code_d;
                        end else begin
                            pend_q  <= '0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.code  = code_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.multi = multi_q;
    assign bus.none  = none_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_enc16x4_seq.sv
// Bench for enc16x4_seq: low- and high-priority instances share stimulus;
// a scoreboard checks every accepted code, tasks check status and timing.
module tb_enc16x4_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    enc16x4_seq_if bus0();
    enc16x4_seq_if bus1();

    enc16x4_seq #(.PRIORITY_LOW(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    enc16x4_seq #(.PRIORITY_LOW(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [3:0] exp0[$];
    logic [3:0] exp1[$];
    logic [3:0] e0, e1;
    int n_cmp = 0;
    int n_bad = 0;

    // Status vector {valid, busy, multi, none, done}
    function automatic logic [4:0] st0();
        return {bus0.valid, bus0.busy, bus0.multi, bus0.none, bus0.done};
    endfunction
    function automatic logic [4:0] st1();
        return {bus1.valid, bus1.busy, bus1.multi, bus1.none, bus1.done};
    endfunction

    task automatic drive(input logic ld, input logic [15:0] d, input logic rdy);
        bus0.load = ld; bus0.d_in = d; bus0.ready = rdy;
        bus1.load = ld; bus1.d_in = d; bus1.ready = rdy;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // Expected emission order for each priority direction
    task automatic push_exp(input logic [15:0] w);
        for (int i = 0; i < 16; i++)  if (w[i]) exp0.push_back(4'(i));
        for (int i = 15; i >= 0; i--) if (w[i]) exp1.push_back(4'(i));
    endtask

    // Scoreboard: a code is consumed at the next edge whenever valid&ready here
    always @(negedge clk) begin
        if (!rst) begin
            if (bus0.valid && bus0.ready) begin
                n_cmp++;
                if (exp0.size() == 0) begin
                    n_bad++; $display("FAIL sb_low_extra: got code %0d, none expected", bus0.code);
                end else begin
                    e0 = exp0.pop_front();
                    if (bus0.code !== e0) begin
                        n_bad++; $display("FAIL sb_low_code: got %0d want %0d", bus0.code, e0);
                    end
                end
            end
            if (bus1.valid && bus1.ready) begin
                n_cmp++;
                if (exp1.size() == 0) begin
                    n_bad++; $display("FAIL sb_high_extra: got code %0d, none expected", bus1.code);
                end else begin
                    e1 = exp1.pop_front();
                    if (bus1.code !== e1) begin
                        n_bad++; $display("FAIL sb_high_code: got %0d want %0d", bus1.code, e1);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        drive(1'b0, 16'h0000, 1'b0);
        cyc(); cyc();
        n_cmp++; if ({bus0.code, st0()} !== 9'd0) begin
            n_bad++; $display("FAIL reset_low: got %b want %b", {bus0.code, st0()}, 9'd0); end
        n_cmp++; if ({bus1.code, st1()} !== 9'd0) begin
            n_bad++; $display("FAIL reset_high: got %b want %b", {bus1.code, st1()}, 9'd0); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single_bit();
        drive(1'b1, 16'h0100, 1'b1); push_exp(16'h0100);
        cyc();
        n_cmp++; if ({bus0.code, st0()} !== {4'd8, 5'b11000}) begin
            n_bad++; $display("FAIL single_first: got %b want %b", {bus0.code, st0()}, {4'd8, 5'b11000}); end
        drive(1'b0, 16'h0000, 1'b1);
        cyc();
        n_cmp++; if ({bus0.code, st0()} !== {4'd8, 5'b00001}) begin
            n_bad++; $display("FAIL single_done: got %b want %b", {bus0.code, st0()}, {4'd8, 5'b00001}); end
        cyc();
        n_cmp++; if (st0() !== 5'b00000) begin
            n_bad++; $display("FAIL single_idle: got %b want %b", st0(), 5'b00000); end
    endtask

    task automatic test_multi_bit();
        drive(1'b1, 16'h8005, 1'b1); push_exp(16'h8005);
        cyc();
        n_cmp++; if ({bus0.code, bus1.code} !== {4'd0, 4'd15}) begin
            n_bad++; $display("FAIL multi_first: got %h want %h", {bus0.code, bus1.code}, 8'h0F); end
        n_cmp++; if ({st0(), st1()} !== {5'b11100, 5'b11100}) begin
            n_bad++; $display("FAIL multi_status: got %b want %b", {st0(), st1()}, 10'b1110011100); end
        drive(1'b0, 16'h0000, 1'b1);
        cyc(); cyc();
        n_cmp++; if ({bus0.code, st0()} !== {4'd15, 5'b11100}) begin
            n_bad++; $display("FAIL multi_third: got %b want %b", {bus0.code, st0()}, {4'd15, 5'b11100}); end
        cyc();
        n_cmp++; if ({st0(), st1()} !== {5'b00101, 5'b00101}) begin
            n_bad++; $display("FAIL multi_done: got %b want %b", {st0(), st1()}, 10'b0010100101); end
        cyc();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 16'h0003, 1'b0); push_exp(16'h0003);
        cyc();
        drive(1'b0, 16'h0000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if ({bus0.code, st0()} !== {4'd0, 5'b11100}) begin
                n_bad++; $display("FAIL bp_hold%0d: got %b want %b", k, {bus0.code, st0()}, {4'd0, 5'b11100}); end
            cyc();
        end
        drive(1'b0, 16'h0000, 1'b1);
        cyc();
        n_cmp++; if ({bus0.code, bus1.code, st0()} !== {4'd1, 4'd0, 5'b11100}) begin
            n_bad++; $display("FAIL bp_second: got %b want %b", {bus0.code, bus1.code, st0()}, {4'd1, 4'd0, 5'b11100}); end
        cyc();
        n_cmp++; if (st0() !== 5'b00101) begin
            n_bad++; $display("FAIL bp_done: got %b want %b", st0(), 5'b00101); end
        cyc();
    endtask

    task automatic test_zero_word();
        drive(1'b1, 16'h0000, 1'b1);
        cyc();
        n_cmp++; if ({st0(), st1()} !== {5'b00010, 5'b00010}) begin
            n_bad++; $display("FAIL zero_none: got %b want %b", {st0(), st1()}, 10'b0001000010); end
        drive(1'b0, 16'h0000, 1'b1);
        cyc();
        n_cmp++; if (st0() !== 5'b00000) begin
            n_bad++; $display("FAIL zero_after: got %b want %b", st0(), 5'b00000); end
    endtask

    task automatic test_load_while_busy();
        drive(1'b1, 16'h0030, 1'b1); push_exp(16'h0030);
        cyc();
        n_cmp++; if ({bus0.code, st0()} !== {4'd4, 5'b11100}) begin
            n_bad++; $display("FAIL busy_first: got %b want %b", {bus0.code, st0()}, {4'd4, 5'b11100}); end
        drive(1'b1, 16'hFFFF, 1'b1);
        cyc();
        n_cmp++; if ({bus0.code, st0()} !== {4'd5, 5'b11100}) begin
            n_bad++; $display("FAIL busy_ignore: got %b want %b", {bus0.code, st0()}, {4'd5, 5'b11100}); end
        cyc();
        n_cmp++; if (st0() !== 5'b00101) begin
            n_bad++; $display("FAIL busy_done: got %b want %b", st0(), 5'b00101); end
        drive(1'b1, 16'h0200, 1'b1); push_exp(16'h0200);
        cyc();
        n_cmp++; if ({bus0.code, st0()} !== {4'd9, 5'b11000}) begin
            n_bad++; $display("FAIL busy_done_load: got %b want %b", {bus0.code, st0()}, {4'd9, 5'b11000}); end
        drive(1'b0, 16'h0000, 1'b1);
        cyc();
        n_cmp++; if (st0() !== 5'b00001) begin
            n_bad++; $display("FAIL busy_done2: got %b want %b", st0(), 5'b00001); end
    endtask

    task automatic test_back_to_back_sweep();
        logic [15:0] w;
        for (int i = 0; i < 16; i++) begin
            w = 16'(1) << i;
            drive(1'b1, w, 1'b1); push_exp(w);
            cyc();
            n_cmp++; if ({bus0.code, bus1.code, st0()} !== {4'(i), 4'(i), 5'b11000}) begin
                n_bad++; $display("FAIL sweep_code%0d: got %b want %b", i, {bus0.code, bus1.code, st0()}, {4'(i), 4'(i), 5'b11000}); end
            drive(1'b0, 16'h0000, 1'b1);
            cyc();
            n_cmp++; if (st0() !== 5'b00001) begin
                n_bad++; $display("FAIL sweep_done%0d: got %b want %b", i, st0(), 5'b00001); end
        end
        cyc();
    endtask

    task automatic test_reset_mid_emit();
        drive(1'b1, 16'hFFFF, 1'b1); push_exp(16'hFFFF);
        cyc();
        drive(1'b0, 16'h0000, 1'b1);
        cyc(); cyc();
        rst = 1'b1;
        #1;
        n_cmp++; if ({bus0.code, st0(), bus1.code, st1()} !== 18'd0) begin
            n_bad++; $display("FAIL rst_mid: got %b want %b", {bus0.code, st0(), bus1.code, st1()}, 18'd0); end
        exp0.delete(); exp1.delete();
        cyc();
        n_cmp++; if ({st0(), st1()} !== 10'd0) begin
            n_bad++; $display("FAIL rst_hold: got %b want %b", {st0(), st1()}, 10'd0); end
        rst = 1'b0;
        cyc();
        n_cmp++; if ({st0(), st1()} !== 10'd0) begin
            n_bad++; $display("FAIL rst_release: got %b want %b", {st0(), st1()}, 10'd0); end
    endtask

    initial begin
        drive(1'b0, 16'h0000, 1'b0);
        test_reset();
        test_single_bit();
        test_multi_bit();
        test_backpressure();
        test_zero_word();
        test_load_while_busy();
        test_back_to_back_sweep();
        test_reset_mid_emit();
        n_cmp++; if (exp0.size() != 0 || exp1.size() != 0) begin
            n_bad++; $display("FAIL sb_leftover: got %0d/%0d codes outstanding want 0/0", exp0.size(), exp1.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
